pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Sequential successor to the combinational next-PC logic.
- Owns the architectural PC register and computes the next PC from the op code.
- Adds stall support, parametrised width and reset vector, and a taken-branch counter.
- Optionally adds a circular return-address stack (RAS) that predicts the target of returns and flags mispredictions.
- Sits between the control unit / register file and instruction memory in the single-cycle CPU.

Parameters:
- XLEN, 32, PC/data width; legal range is XLEN ≥ 32.
- RESET_VEC, 32'h0000_3000, PC value loaded on reset. Width is XLEN.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, 2..16.
- CNT_W, 32, width of the taken-branch counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  1 = hold PC and all state this cycle.
- npc_op  in  2  00 seq, 01 cond branch, 10 jump register, 11 jump absolute.
- is_jump  in  1  branch condition result; used only when npc_op=01.
- imm  in  26  instr[25:0]: low 16 bits are the branch offset, all 26 bits are the jump index.
- ra  in  XLEN  register-file operand for jump-register.
- is_call  in  1  current instruction is a call (jal/jalr); qualifies npc_op 11/10.
- is_ret  in  1  current instruction is a return (jr $ra); qualifies npc_op 10.
- pc  out  XLEN  current PC (registered).
- pc4  out  XLEN  pc+4, combinational; serves as the link value.
- npc  out  XLEN  next PC, combinational.
- br_taken_cnt  out  CNT_W  count of taken conditional branches.
- ras_top  out  XLEN  RAS top entry; 0 when RAS is compiled out.
- ras_miss  out  1  combinational, RAS misprediction on the current return; 0 when compiled out.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC, br_taken_cnt=0, RAS pointer=0, RAS count=0, all RAS entries=0.
- Release of reset is synchronised by the integrator; the block samples nothing while rst_n=0.
- All arithmetic is modulo 2^XLEN; wrap-around is silent.
- pc4 = pc+4.
- offset = sign-extend(imm[15:0]) << 2, extended to XLEN.
- jump target = {pc4[XLEN-1:28], imm[25:0], 2'b00}. The upper bits come from pc4 and are not zeroed.
- npc selection:
  - npc_op=00: pc4.
  - npc_op=01: is_jump ? pc4+offset : pc4.
  - npc_op=10: ra. Architectural; the RAS never redirects.
  - npc_op=11: jump target.
- Latency: npc is combinational; pc takes npc on the next rising edge when stall=0.
- stall=1: pc, counter and RAS all hold; outputs still reflect the held pc.
- br_taken_cnt: increments when stall=0 and npc_op=01 and is_jump=1. Wraps from all-ones to 0.
- Undefined qualifier use:
  - is_call/is_ret are ignored unless npc_op is 11/10 (is_call) or 10 (is_ret).
  - is_call and is_ret both set in the same cycle is treated as return then call (see RAS).

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined: a circular RAS_DEPTH-entry stack with pointer sp and occupancy count cnt (0..RAS_DEPTH). Updates happen only when stall=0:
  - Push (is_call with op 10/11): entry[sp+1] = pc4; sp += 1; cnt = min(cnt+1, RAS_DEPTH).
  - When full, a push overwrites the oldest entry silently.
  - Pop (is_ret with op 10): sp -= 1 and cnt -= 1 if cnt > 0; on empty, nothing changes.
  - Pop and push in the same cycle: entry[sp] = pc4; sp and cnt are unchanged.
  - ras_top = entry[sp] when cnt > 0, else 0.
  - ras_miss = is_ret & (npc_op==10) & (cnt==0 | ras_top≠ra). It is asserted even while stall=1, for use by the perf monitor.
- Not defined: no RAS storage is built; ras_top=0 and ras_miss=0 tied off; npc behaviour is identical.

Test Plan:
- Reset and sequential run:
  - Pulse rst_n low mid-cycle -> pc=32'h3000 immediately, without waiting for a clock edge.
  - Then 3 cycles with op 00 -> pc = 3004, 3008, 300C.
- Conditional branch:
  - pc=3010, op 01, imm=16'hFFFE, is_jump=1 -> npc=300C; br_taken_cnt increments to 1.
  - Same with is_jump=0 -> npc=3014; counter unchanged.
- Jump absolute:
  - pc=F000_0000, op 11, imm=26'h0000100 -> npc=F000_0400 (upper bits taken from pc4).
- Stall:
  - Hold stall=1 for 4 cycles with op 01 and is_jump=1 -> pc and br_taken_cnt frozen.
  - Release stall -> pc advances exactly once.
- RAS, PC_GEN_RAS_EN defined, RAS_DEPTH=4:
  - 5 calls from pcs 100, 200, 300, 400, 500, then 5 returns with ra = 504, 404, 304, 204, 104.
  - Required: ras_miss=0 for the first 4 returns; ras_miss=1 on the 5th (stack empty after overflow).
- Call and return in the same cycle, plus macro undefined:
  - With RAS holding top=204, apply a call+ret at pc=600 -> ras_top becomes 604; occupancy unchanged.
  - With the macro undefined, the same sequence -> ras_miss stays 0 and npc values are identical.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: owns the PC register, selects the next PC, counts taken branches.
// Define PC_GEN_RAS_EN to build the circular return-address stack that flags mispredicted returns.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_3000),
    parameter int              RAS_DEPTH = 4,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       npc_op,
    input  logic             is_jump,
    input  logic [25:0]      imm,
    input  logic [XLEN-1:0]  ra,
    input  logic             is_call,
    input  logic             is_ret,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc4,
    output logic [XLEN-1:0]  npc,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [XLEN-1:0]  ras_top,
    output logic             ras_miss
);

    localparam logic [1:0] OP_SEQ = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_JR  = 2'b10;
    localparam logic [1:0] OP_JA  = 2'b11;

    function automatic logic signed [XLEN-1:0] br_offset(input logic [15:0] off);
        logic signed [XLEN-1:0] ext;
        ext = {{(XLEN-16){off[15]}}, off};
        return ext <<< 2;
    endfunction

    logic signed [XLEN-1:0] offset;
    logic [XLEN-1:0]        br_target;
    logic [XLEN-1:0]        jump_target;
    logic                   br_taken;

    assign pc4         = pc + XLEN'(4);
    assign offset      = br_offset(imm[15:0]);
    assign br_target   = pc4 + $unsigned(offset);
    // Region bits come from pc4, so a jump placed at the top of a region crosses into the next one.
    assign jump_target = {pc4[XLEN-1:28], imm, 2'b00};
    assign br_taken    = (npc_op == OP_BR) && is_jump;

    always_comb begin
        npc = pc4;
        case (npc_op)
            OP_SEQ: npc = pc4;
            OP_BR:  npc = is_jump ? br_target : pc4;
            OP_JR:  npc = ra;
            OP_JA:  npc = jump_target;
            default: npc = pc4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_VEC;
            br_taken_cnt <= '0;
        end else if (!stall) begin
            pc <= npc;
            if (br_taken) br_taken_cnt <= br_taken_cnt + CNT_W'(1);
        end
    end

`ifdef PC_GEN_RAS_EN
    localparam int SP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W:0]   occ;
    logic            push;
    logic            pop;

    assign push = is_call && npc_op[1];
    assign pop  = is_ret && (npc_op == OP_JR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            occ <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (!stall) begin
            // A return-then-call replaces the top in place; depth and pointer stay put.
            if (push && pop) begin
                ras_mem[sp] <= pc4;
            end else if (push) begin
                ras_mem[sp + SP_W'(1)] <= pc4;
                sp <= sp + SP_W'(1);
                if (occ != (SP_W+1)'(RAS_DEPTH)) occ <= occ + (SP_W+1)'(1);
            end else if (pop && (occ != '0)) begin
                sp  <= sp - SP_W'(1);
                occ <= occ - (SP_W+1)'(1);
            end
        end
    end

    assign ras_top  = (occ != '0) ? ras_mem[sp] : '0;
    assign ras_miss = pop && ((occ == '0) || (ras_top != ra));
`else
    logic unused_qual;
    assign unused_qual = ^{is_call, is_ret};
    assign ras_top     = '0;
    assign ras_miss    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; RAS expectations follow whether PC_GEN_RAS_EN is defined.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  npc_op;
    logic        is_jump;
    logic [25:0] imm;
    logic [31:0] ra;
    logic        is_call;
    logic        is_ret;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] npc;
    logic [31:0] br_taken_cnt;
    logic [31:0] ras_top;
    logic        ras_miss;

    int n_pass  = 0;
    int n_total = 0;

    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc_op(npc_op), .is_jump(is_jump),
        .imm(imm), .ra(ra), .is_call(is_call), .is_ret(is_ret), .pc(pc), .pc4(pc4),
        .npc(npc), .br_taken_cnt(br_taken_cnt), .ras_top(ras_top), .ras_miss(ras_miss)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; npc_op = 2'b00; is_jump = 0; imm = '0; ra = '0; is_call = 0; is_ret = 0;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        idle_inputs();
        npc_op = 2'b10; ra = addr;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        idle_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        n_total++; if (pc !== 32'h3000) $display("FAIL reset_pc actual=%h required=%h", pc, 32'h3000); else n_pass++;
        n_total++; if (br_taken_cnt !== 32'd0) $display("FAIL reset_cnt actual=%0d required=0", br_taken_cnt); else n_pass++;
        n_total++; if (ras_top !== 32'd0) $display("FAIL reset_ras_top actual=%h required=0", ras_top); else n_pass++;
        n_total++; if (ras_miss !== 1'b0) $display("FAIL reset_ras_miss actual=%b required=0", ras_miss); else n_pass++;
        @(negedge clk); rst_n = 1;
        step(); step();
        // Mid-cycle pulse: pc must return to the vector before any clock edge.
        @(negedge clk); #2 rst_n = 0;
        #1;
        n_total++; if (pc !== 32'h3000) $display("FAIL async_reset_pc actual=%h required=%h", pc, 32'h3000); else n_pass++;
        #1 rst_n = 1;
        exp_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            n_total++; if (pc !== exp_pc) $display("FAIL seq_pc%0d actual=%h required=%h", i, pc, exp_pc); else n_pass++;
        end
        n_total++; if (pc4 !== 32'h3010) $display("FAIL seq_pc4 actual=%h required=%h", pc4, 32'h3010); else n_pass++;
    endtask

    task automatic test_branch();
        jump_to(32'h3010);
        npc_op = 2'b01; imm = 26'h000FFFE; is_jump = 1;
        #1;
        n_total++; if (npc !== 32'h300C) $display("FAIL br_taken_npc actual=%h required=%h", npc, 32'h300C); else n_pass++;
        step();
        n_total++; if (pc !== 32'h300C) $display("FAIL br_taken_pc actual=%h required=%h", pc, 32'h300C); else n_pass++;
        n_total++; if (br_taken_cnt !== 32'd1) $display("FAIL br_cnt1 actual=%0d required=1", br_taken_cnt); else n_pass++;
        jump_to(32'h3010);
        npc_op = 2'b01; imm = 26'h000FFFE; is_jump = 0;
        #1;
        n_total++; if (npc !== 32'h3014) $display("FAIL br_not_npc actual=%h required=%h", npc, 32'h3014); else n_pass++;
        step();
        n_total++; if (pc !== 32'h3014) $display("FAIL br_not_pc actual=%h required=%h", pc, 32'h3014); else n_pass++;
        n_total++; if (br_taken_cnt !== 32'd1) $display("FAIL br_cnt_hold actual=%0d required=1", br_taken_cnt); else n_pass++;
        npc_op = 2'b01; imm = 26'h0000010; is_jump = 1;
        #1;
        n_total++; if (npc !== 32'h3058) $display("FAIL br_fwd_npc actual=%h required=%h", npc, 32'h3058); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_jump();
        jump_to(32'hF000_0000);
        npc_op = 2'b11; imm = 26'h0000100;
        #1;
        n_total++; if (npc !== 32'hF000_0400) $display("FAIL jabs_npc actual=%h required=%h", npc, 32'hF000_0400); else n_pass++;
        step();
        n_total++; if (pc !== 32'hF000_0400) $display("FAIL jabs_pc actual=%h required=%h", pc, 32'hF000_0400); else n_pass++;
        jump_to(32'h0FFF_FFFC);
        npc_op = 2'b11; imm = 26'h3FFFFFF;
        #1;
        n_total++; if (npc !== 32'h1FFF_FFFC) $display("FAIL jabs_region_npc actual=%h required=%h", npc, 32'h1FFF_FFFC); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stall();
        jump_to(32'h4000);
        npc_op = 2'b01; is_jump = 1; imm = 26'h0000004; stall = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if (pc !== 32'h4000) $display("FAIL stall_pc%0d actual=%h required=%h", i, pc, 32'h4000); else n_pass++;
            n_total++; if (br_taken_cnt !== 32'd1) $display("FAIL stall_cnt%0d actual=%0d required=1", i, br_taken_cnt); else n_pass++;
        end
        n_total++; if (npc !== 32'h4014) $display("FAIL stall_npc actual=%h required=%h", npc, 32'h4014); else n_pass++;
        stall = 0;
        step();
        n_total++; if (pc !== 32'h4014) $display("FAIL unstall_pc actual=%h required=%h", pc, 32'h4014); else n_pass++;
        n_total++; if (br_taken_cnt !== 32'd2) $display("FAIL unstall_cnt actual=%0d required=2", br_taken_cnt); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (pc !== 32'h4018) $display("FAIL post_stall_pc actual=%h required=%h", pc, 32'h4018); else n_pass++;
    endtask

    task automatic test_ras();
        logic [31:0] exp_top;
        logic        exp_miss;
        jump_to(32'h100);
        for (int i = 1; i <= 5; i++) begin
            npc_op = 2'b10; is_call = 1; ra = 32'h100 * (i + 1);
            step();
        end
        idle_inputs();
        exp_top = RAS_ON ? 32'h504 : 32'h0;
        n_total++; if (ras_top !== exp_top) $display("FAIL ras_top_after_calls actual=%h required=%h", ras_top, exp_top); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            npc_op = 2'b10; is_ret = 1; ra = 32'h504 - 32'h100 * i;
            #1;
            exp_miss = RAS_ON && (i == 4);
            exp_top  = (RAS_ON && i < 4) ? ra : 32'h0;
            n_total++; if (ras_miss !== exp_miss) $display("FAIL ret%0d_miss actual=%b required=%b", i, ras_miss, exp_miss); else n_pass++;
            n_total++; if (ras_top !== exp_top) $display("FAIL ret%0d_top actual=%h required=%h", i, ras_top, exp_top); else n_pass++;
            n_total++; if (npc !== ra) $display("FAIL ret%0d_npc actual=%h required=%h", i, npc, ra); else n_pass++;
            step();
        end
        // Return on an empty stack while stalled: miss is still visible, nothing moves.
        stall = 1; npc_op = 2'b10; is_ret = 1; ra = 32'h0;
        #1;
        exp_miss = RAS_ON;
        n_total++; if (ras_miss !== exp_miss) $display("FAIL stall_ret_miss actual=%b required=%b", ras_miss, exp_miss); else n_pass++;
        step();
        n_total++; if (pc !== 32'h104) $display("FAIL stall_ret_pc actual=%h required=%h", pc, 32'h104); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_call_ret();
        logic [31:0] exp_top;
        logic        exp_miss;
        jump_to(32'h100);
        npc_op = 2'b10; is_call = 1; ra = 32'h200;
        step();
        npc_op = 2'b10; is_call = 1; ra = 32'h600;
        step();
        exp_top = RAS_ON ? 32'h204 : 32'h0;
        n_total++; if (ras_top !== exp_top) $display("FAIL cr_top_before actual=%h required=%h", ras_top, exp_top); else n_pass++;
        is_ret = 1; ra = 32'h700;
        #1;
        exp_miss = RAS_ON;
        n_total++; if (ras_miss !== exp_miss) $display("FAIL cr_miss actual=%b required=%b", ras_miss, exp_miss); else n_pass++;
        n_total++; if (npc !== 32'h700) $display("FAIL cr_npc actual=%h required=%h", npc, 32'h700); else n_pass++;
        step();
        idle_inputs();
        exp_top = RAS_ON ? 32'h604 : 32'h0;
        n_total++; if (ras_top !== exp_top) $display("FAIL cr_top_after actual=%h required=%h", ras_top, exp_top); else n_pass++;
        // Occupancy must still be two: two matching returns, then an empty-stack miss.
        for (int i = 0; i < 3; i++) begin
            npc_op = 2'b10; is_ret = 1;
            ra = (i == 0) ? 32'h604 : ((i == 1) ? 32'h104 : 32'h900);
            #1;
            exp_miss = RAS_ON && (i == 2);
            n_total++; if (ras_miss !== exp_miss) $display("FAIL cr_ret%0d_miss actual=%b required=%b", i, ras_miss, exp_miss); else n_pass++;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_ras();
        test_call_ret();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
